// File: rtl/dup_detect_param.sv
// Duplicate/range checker for HQC fixed-weight support sampling; optional reject counters via DUP_DETECT_STATS_EN.
// Latency: 2 cycles per candidate (ISSUE + CHECK), then WEIGHT valid/ready transfers from the accepted array.
// Backpressure: out_loc is held stable while out_ready is low; MODE 0 halts on a reject until resume.
module dup_detect_param #(
    parameter int LOC_W    = 15,
    parameter int WEIGHT   = 75,
    parameter int LIST_LEN = 96,
    parameter int ADDR_W   = 7,
    parameter int RANGE    = 17669,
    parameter int MODE     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [LOC_W-1:0]  rd_data,
    output logic              collision,
    output logic [ADDR_W-1:0] coll_addr,
    input  logic              resume,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LOC_W-1:0]  out_loc,
    output logic              busy,
    output logic              done,
    output logic              fail
`ifdef DUP_DETECT_STATS_EN
    ,
    output logic [7:0]        rej_dup,
    output logic [7:0]        rej_range
`endif
);

    localparam int CNT_W = $clog2(WEIGHT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WEIGHT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W:0]   PTR_END  = (ADDR_W + 1)'(LIST_LEN);
    localparam logic [ADDR_W:0]   PTR_ONE  = (ADDR_W + 1)'(1);
    localparam logic [LOC_W:0]    RANGE_V  = (LOC_W + 1)'(RANGE);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_CHECK, S_HALT, S_EMIT, S_FAIL, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    idx_q;
    logic [WEIGHT-1:0]   acc_vld;
    logic [LOC_W-1:0]    acc [WEIGHT];

    logic                dup_hit;
    logic                in_range;
    logic                cand_ok;
    logic [ADDR_W:0]     ptr_inc;
    logic                last_cand;
    logic                last_acc;

    // Only slots filled in this run take part, so stale contents never match.
    always_comb begin
        dup_hit = 1'b0;
        for (int k = 0; k < WEIGHT; k++) begin
            if (acc_vld[k] && (acc[k] == rd_data)) begin
                dup_hit = 1'b1;
            end
        end
    end

    assign in_range  = ({1'b0, rd_data} < RANGE_V);
    assign cand_ok   = in_range && !dup_hit;
    assign ptr_inc   = ptr_q + PTR_ONE;
    assign last_cand = (ptr_inc == PTR_END);
    assign last_acc  = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ISSUE;
            S_ISSUE: state_d = S_CHECK;
            S_CHECK: begin
                if (cand_ok) begin
                    if (last_acc)
                        state_d = S_EMIT;
                    else if ((MODE != 0) && last_cand)
                        state_d = S_FAIL;
                    else
                        state_d = S_ISSUE;
                end else if (MODE == 0) begin
                    state_d = S_HALT;
                end else if (last_cand) begin
                    state_d = S_FAIL;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_HALT:  if (resume) state_d = S_ISSUE;
            S_EMIT:  if (out_ready && (idx_q == CNT_LAST)) state_d = S_DONE;
            S_FAIL:  state_d = S_IDLE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode straight from state so an async reset clears them at once.
    always_comb begin
        rd_en     = (state_q == S_ISSUE);
        rd_addr   = rd_en ? ptr_q[ADDR_W-1:0] : '0;
        collision = (state_q == S_HALT);
        coll_addr = collision ? ptr_q[ADDR_W-1:0] : '0;
        out_valid = (state_q == S_EMIT);
        out_loc   = out_valid ? acc[idx_q] : '0;
        busy      = (state_q == S_ISSUE) || (state_q == S_CHECK) ||
                    (state_q == S_HALT)  || (state_q == S_EMIT);
        done      = (state_q == S_DONE) || (state_q == S_FAIL);
        fail      = (state_q == S_FAIL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            acc_vld <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && start) begin
                ptr_q   <= '0;
                cnt_q   <= '0;
                idx_q   <= '0;
                acc_vld <= '0;
            end
            if (state_q == S_CHECK) begin
                if (cand_ok) begin
                    acc_vld[cnt_q] <= 1'b1;
                    cnt_q          <= cnt_q + CNT_ONE;
                    ptr_q          <= ptr_inc;
                end else if (MODE != 0) begin
                    ptr_q <= ptr_inc;
                end
            end
            if ((state_q == S_EMIT) && out_ready) begin
                idx_q <= idx_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if ((state_q == S_CHECK) && cand_ok) begin
            acc[cnt_q] <= rd_data;
        end
    end

`ifdef DUP_DETECT_STATS_EN
    logic [7:0] rej_dup_q;
    logic [7:0] rej_range_q;

    // Range takes priority when classifying, since an out-of-range value may also match nothing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rej_dup_q   <= '0;
            rej_range_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            rej_dup_q   <= '0;
            rej_range_q <= '0;
        end else if ((state_q == S_CHECK) && !cand_ok) begin
            if (!in_range) begin
                if (rej_range_q != 8'hFF) rej_range_q <= rej_range_q + 8'd1;
            end else begin
                if (rej_dup_q != 8'hFF) rej_dup_q <= rej_dup_q + 8'd1;
            end
        end
    end

    assign rej_dup   = rej_dup_q;
    assign rej_range = rej_range_q;
`endif

endmodule

// File: tb/tb_dup_detect_param.sv
// Directed bench for dup_detect_param: one MODE 0 and one MODE 1 instance, each with its own location RAM.
// A select bit steers the shared stimulus to one instance and muxes that instance's outputs for checking.
module tb_dup_detect_param;

    localparam int LOC_W    = 15;
    localparam int WEIGHT   = 75;
    localparam int LIST_LEN = 96;
    localparam int ADDR_W   = 7;
    localparam int RANGE    = 17669;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic sel;
    logic start_c, resume_c, ready_c;

    logic              start0, resume0, ready0, rd_en0, collision0, out_valid0, busy0, done0, fail0;
    logic [ADDR_W-1:0] rd_addr0, coll_addr0;
    logic [LOC_W-1:0]  rd_data0, out_loc0;
    logic              start1, resume1, ready1, rd_en1, collision1, out_valid1, busy1, done1, fail1;
    logic [ADDR_W-1:0] rd_addr1, coll_addr1;
    logic [LOC_W-1:0]  rd_data1, out_loc1;
`ifdef DUP_DETECT_STATS_EN
    logic [7:0] rej_dup0, rej_range0, rej_dup1, rej_range1;
`endif

    assign start0  = start_c  & ~sel;
    assign resume0 = resume_c & ~sel;
    assign ready0  = ready_c  & ~sel;
    assign start1  = start_c  & sel;
    assign resume1 = resume_c & sel;
    assign ready1  = ready_c  & sel;

    logic [LOC_W-1:0] ram0 [128];
    logic [LOC_W-1:0] ram1 [128];

    always_ff @(posedge clk) if (rd_en0) rd_data0 <= ram0[rd_addr0];
    always_ff @(posedge clk) if (rd_en1) rd_data1 <= ram1[rd_addr1];

    dup_detect_param #(.LOC_W(LOC_W), .WEIGHT(WEIGHT), .LIST_LEN(LIST_LEN), .ADDR_W(ADDR_W),
                       .RANGE(RANGE), .MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .rd_en(rd_en0), .rd_addr(rd_addr0),
        .rd_data(rd_data0), .collision(collision0), .coll_addr(coll_addr0), .resume(resume0),
        .out_valid(out_valid0), .out_ready(ready0), .out_loc(out_loc0), .busy(busy0),
        .done(done0), .fail(fail0)
`ifdef DUP_DETECT_STATS_EN
        , .rej_dup(rej_dup0), .rej_range(rej_range0)
`endif
    );

    dup_detect_param #(.LOC_W(LOC_W), .WEIGHT(WEIGHT), .LIST_LEN(LIST_LEN), .ADDR_W(ADDR_W),
                       .RANGE(RANGE), .MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .rd_data(rd_data1), .collision(collision1), .coll_addr(coll_addr1), .resume(resume1),
        .out_valid(out_valid1), .out_ready(ready1), .out_loc(out_loc1), .busy(busy1),
        .done(done1), .fail(fail1)
`ifdef DUP_DETECT_STATS_EN
        , .rej_dup(rej_dup1), .rej_range(rej_range1)
`endif
    );

    logic              c_valid, c_coll, c_done, c_fail, c_busy, c_rden;
    logic [ADDR_W-1:0] c_caddr;
    logic [LOC_W-1:0]  c_loc;

    always_comb begin
        c_valid = sel ? out_valid1 : out_valid0;
        c_coll  = sel ? collision1 : collision0;
        c_done  = sel ? done1      : done0;
        c_fail  = sel ? fail1      : fail0;
        c_busy  = sel ? busy1      : busy0;
        c_rden  = sel ? rd_en1     : rd_en0;
        c_caddr = sel ? coll_addr1 : coll_addr0;
        c_loc   = sel ? out_loc1   : out_loc0;
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [LOC_W-1:0] exp_q [WEIGHT];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_c = 1'b1;
        step();
        start_c = 1'b0;
    endtask

    task automatic wait_valid(output int n, output logic seen_coll);
        n = 0;
        seen_coll = 1'b0;
        while (!c_valid && n < 2000) begin
            if (c_coll) seen_coll = 1'b1;
            step();
            n++;
        end
    endtask

    task automatic wait_coll(output int n);
        n = 0;
        while (!c_coll && n < 2000) begin
            step();
            n++;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " ctl0"}, 32'({rd_en0, collision0, out_valid0, busy0, done0, fail0}), 0);
        check({tag, " bus0"}, 32'({rd_addr0, coll_addr0, out_loc0}), 0);
        check({tag, " ctl1"}, 32'({rd_en1, collision1, out_valid1, busy1, done1, fail1}), 0);
        check({tag, " bus1"}, 32'({rd_addr1, coll_addr1, out_loc1}), 0);
    endtask

    task automatic drain(input string tag);
        ready_c = 1'b1;
        for (int i = 0; i < WEIGHT; i++) begin
            check($sformatf("%s vld%0d", tag, i), 32'(c_valid), 1);
            check($sformatf("%s loc%0d", tag, i), 32'(c_loc), 32'(exp_q[i]));
            step();
        end
        ready_c = 1'b0;
        check({tag, " done"}, 32'(c_done), 1);
        check({tag, " fail"}, 32'(c_fail), 0);
        check({tag, " busy"}, 32'(c_busy), 0);
        step();
        check({tag, " done pulse"}, 32'(c_done), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   idx;
        logic seen;

        rst = 1'b1; sel = 1'b0; start_c = 1'b0; resume_c = 1'b0; ready_c = 1'b0;
        for (int k = 0; k < 128; k++) begin
            ram0[k] = LOC_W'(k);
            ram1[k] = LOC_W'(k);
        end
        #1 rst = 1'b0;
        #1 check_idle("reset");
        repeat (2) step();
        rst = 1'b1;
        step();

        // Clean MODE 0 run; a stray start+resume during ISSUE must be ignored.
        for (int k = 0; k < WEIGHT; k++) exp_q[k] = LOC_W'(k);
        pulse_start();
        start_c = 1'b1; resume_c = 1'b1;
        step();
        start_c = 1'b0; resume_c = 1'b0;
        wait_valid(n, seen);
        check("t1 valid latency", 32'(n + 1), 150);
        check("t1 no collision", 32'(seen), 0);
        drain("t1");

        // Duplicate at entry 10, repaired externally.
        ram0[10] = 15'd3;
        exp_q[10] = 15'd500;
        pulse_start();
        wait_coll(n);
        check("t2 coll latency", 32'(n), 22);
        check("t2 coll_addr", 32'(c_caddr), 10);
        check("t2 busy", 32'(c_busy), 1);
        repeat (3) step();
        check("t2 coll held", 32'(c_coll), 1);
        check("t2 coll_addr held", 32'(c_caddr), 10);
        check("t2 no read in halt", 32'(c_rden), 0);
        ram0[10] = 15'd500;
        resume_c = 1'b1; start_c = 1'b1;
        step();
        resume_c = 1'b0; start_c = 1'b0;
        check("t2 coll dropped", 32'(c_coll), 0);
        wait_valid(n, seen);
        check("t2 valid after resume", 32'(n), 130);
        drain("t2");
        ram0[10] = 15'd10;
        exp_q[10] = 15'd10;

        // Out-of-range first entry: only the RANGE check can reject it.
        ram0[0] = 15'd17669;
        pulse_start();
        wait_coll(n);
        check("t3 coll latency", 32'(n), 2);
        check("t3 coll_addr", 32'(c_caddr), 0);
        ram0[0] = 15'd0;
        resume_c = 1'b1;
        step();
        resume_c = 1'b0;
        wait_valid(n, seen);
        check("t3 valid after resume", 32'(n), 150);
        drain("t3");

        // MODE 1 skip: dups at 20 and 40, out-of-range at 30, RANGE-1 accepted at 31.
        sel = 1'b1;
        for (int k = 0; k < 128; k++) ram1[k] = LOC_W'(100 + k);
        ram1[20] = 15'd105;
        ram1[30] = 15'd17669;
        ram1[31] = 15'd17668;
        ram1[40] = 15'd107;
        idx = 0;
        for (int a = 0; a < 78; a++) begin
            if (a != 20 && a != 30 && a != 40) begin
                exp_q[idx] = (a == 31) ? 15'd17668 : LOC_W'(100 + a);
                idx++;
            end
        end
        pulse_start();
        wait_valid(n, seen);
        check("t4 valid latency", 32'(n), 156);
        check("t4 no collision", 32'(seen), 0);
        drain("t4");
`ifdef DUP_DETECT_STATS_EN
        check("t4 rej_dup", 32'(rej_dup1), 2);
        check("t4 rej_range", 32'(rej_range1), 1);
`endif

        // MODE 1 exhaustion: 66 unique then 30 repeats.
        for (int k = 0; k < 128; k++) ram1[k] = (k < 66) ? LOC_W'(100 + k) : LOC_W'(100 + k - 66);
        pulse_start();
        n = 0;
        seen = 1'b0;
        while (!c_done && n < 2000) begin
            if (c_valid) seen = 1'b1;
            step();
            n++;
        end
        check("t5 done latency", 32'(n), 192);
        check("t5 done", 32'(c_done), 1);
        check("t5 fail", 32'(c_fail), 1);
        check("t5 busy", 32'(c_busy), 0);
        check("t5 never valid", 32'(seen), 0);
`ifdef DUP_DETECT_STATS_EN
        check("t5 rej_dup", 32'(rej_dup1), 30);
        check("t5 rej_range", 32'(rej_range1), 0);
`endif
        step();
        check("t5 done pulse", 32'({c_done, c_fail}), 0);

        // MODE 0 emit with out_ready toggling every cycle.
        sel = 1'b0;
        for (int k = 0; k < WEIGHT; k++) exp_q[k] = LOC_W'(k);
        pulse_start();
        wait_valid(n, seen);
        check("t6 valid latency", 32'(n), 150);
        idx = 0;
        for (int c = 0; c < 149; c++) begin
            ready_c = (c % 2 == 0);
            if (idx < WEIGHT) begin
                check($sformatf("t6 vld c%0d", c), 32'(c_valid), 1);
                check($sformatf("t6 loc c%0d", c), 32'(c_loc), 32'(exp_q[idx]));
            end
            if (ready_c) idx++;
            step();
        end
        ready_c = 1'b0;
        check("t6 done after 75 transfers", 32'(c_done), 1);
        step();

        // Reset mid-EMIT clears all outputs without a clock edge.
        pulse_start();
        wait_valid(n, seen);
        ready_c = 1'b1;
        repeat (5) step();
        check("t7 emitting", 32'(c_valid), 1);
        #2 rst = 1'b0;
        #1 check_idle("t7 async reset");
        #2 rst = 1'b1;
        ready_c = 1'b0;
        step();
        check("t7 idle after reset", 32'({c_valid, c_busy, c_done}), 0);
        pulse_start();
        check("t7 restart busy", 32'(c_busy), 1);
        check("t7 restart read", 32'(c_rden), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
